// File: rtl/axis_parity_appender.sv
// axis_parity_appender
// Forwards each packet's data bytes unchanged, then appends one LRC byte
// (XOR of all packet bytes, optionally inverted) that carries m_tlast.
// Packets longer than MAX_LEN bytes are closed after byte MAX_LEN.
// The remaining bytes start a new packet.

module axis_parity_appender #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int MAX_LEN    = 256
) (
  input  logic              in_clock,
  input  logic              axis_aresetn,
  input  logic              axis_s_tvalid,
  input  logic [DATA_W-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  output logic              axis_s_tready,
  output logic              axis_m_tvalid,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  input  logic              axis_m_tready,
  output logic [15:0]       pkt_count,
  output logic              err_len,
  output logic              dbg_state
);

  // Length counter only needs to reach MAX_LEN-1; it is reset when a packet closes.
  localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0]  LEN_LAST = LEN_W'(MAX_LEN - 1);
  localparam logic [DATA_W-1:0] LRC_MASK = {DATA_W{PARITY_ODD}};

  typedef enum logic {
    S_PASS   = 1'b0,
    S_APPEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              err_len_q, err_len_d;

  logic slot_free;
  logic accept;
  logic at_max;

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high. The output register loads only when it is empty or being drained
  // this cycle (slot_free). While valid is high and ready is low, the output
  // data, last and valid hold their values. Upstream is only accepted in
  // S_PASS; the LRC slot in S_APPEND inserts one input bubble per packet.
  assign slot_free     = !m_tvalid_q || axis_m_tready;
  assign axis_s_tready = (state_q == S_PASS) && slot_free;
  assign accept        = axis_s_tvalid && axis_s_tready;
  assign at_max        = (len_q == LEN_LAST);

  // Next-state and datapath: pass data bytes, then load the LRC beat.
  always_comb begin
    state_d     = state_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    acc_d       = acc_q;
    len_d       = len_q;
    pkt_count_d = pkt_count_q;
    err_len_d   = err_len_q;
    case (state_q)
      S_PASS: begin
        if (accept) begin
          m_tdata_d  = axis_s_tdata;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          acc_d      = acc_q ^ axis_s_tdata;
          len_d      = len_q + LEN_W'(1);
          if (axis_s_tlast || at_max) begin
            state_d = S_APPEND;
            len_d   = '0;
          end
          if (at_max && !axis_s_tlast) begin
            err_len_d = 1'b1;
          end
        end else if (axis_m_tready) begin
          m_tvalid_d = 1'b0;
        end
      end
      S_APPEND: begin
        // acc already includes the last data byte of the packet.
        if (slot_free) begin
          m_tdata_d   = acc_q ^ LRC_MASK;
          m_tlast_d   = 1'b1;
          m_tvalid_d  = 1'b1;
          acc_d       = '0;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = S_PASS;
        end
      end
      default: begin
        state_d = S_PASS;
      end
    endcase
  end

  // State and output registers; a reset in mid-packet discards the partial packet.
  always_ff @(posedge in_clock or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= S_PASS;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      acc_q       <= '0;
      len_q       <= '0;
      pkt_count_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      pkt_count_q <= pkt_count_d;
      err_len_q   <= err_len_d;
    end
  end

  assign axis_m_tvalid = m_tvalid_q;
  assign axis_m_tdata  = m_tdata_q;
  assign axis_m_tlast  = m_tlast_q;
  assign pkt_count     = pkt_count_q;
  assign err_len       = err_len_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_parity_appender.sv
// Testbench for axis_parity_appender.
// Four instances: dut0 (even, 256), dut1 (odd, 256), dut2 (even, MAX_LEN=4),
// dut3 (even, MAX_LEN=1). A model of the LRC pushes {tlast,data} to exp_q as
// bytes are accepted. The output collector records beats that are transferred.

module tb_axis_parity_appender;

  localparam int NI = 4;
  localparam logic [3:0]      ODD_P  = 4'b0010;
  localparam logic [3:0][8:0] MAXL_P = {9'd1, 9'd4, 9'd256, 9'd256};

  // clock / reset
  logic in_clock = 1'b0;
  logic axis_aresetn;
  always #5 in_clock = ~in_clock;

  logic        s_tvalid [NI];
  logic [7:0]  s_tdata  [NI];
  logic        s_tlast  [NI];
  logic        s_tready [NI];
  logic        m_tvalid [NI];
  logic [7:0]  m_tdata  [NI];
  logic        m_tlast  [NI];
  logic        m_tready [NI];
  logic [15:0] pkt_count[NI];
  logic        err_len  [NI];
  logic        dbg_state[NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] mdl_acc;
  int         mdl_len;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axis_parity_appender #(
      .DATA_W    (8),
      .PARITY_ODD(ODD_P[g]),
      .MAX_LEN   (int'(MAXL_P[g]))
    ) dut (
      .in_clock     (in_clock),
      .axis_aresetn (axis_aresetn),
      .axis_s_tvalid(s_tvalid[g]),
      .axis_s_tdata (s_tdata[g]),
      .axis_s_tlast (s_tlast[g]),
      .axis_s_tready(s_tready[g]),
      .axis_m_tvalid(m_tvalid[g]),
      .axis_m_tdata (m_tdata[g]),
      .axis_m_tlast (m_tlast[g]),
      .axis_m_tready(m_tready[g]),
      .pkt_count    (pkt_count[g]),
      .err_len      (err_len[g]),
      .dbg_state    (dbg_state[g])
    );
  end

  // driver tasks
  task automatic apply_reset();
    @(negedge in_clock);
    axis_aresetn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = 8'h00;
      s_tlast[i]  = 1'b0;
      m_tready[i] = 1'b1;
    end
    exp_q.delete();
    obs_q.delete();
    mdl_acc = 8'h00;
    mdl_len = 0;
    repeat (2) @(negedge in_clock);
    axis_aresetn = 1'b1;
    @(negedge in_clock);
  endtask

  // Offer one byte until accepted; on acceptance push the model's expected beats.
  task automatic send_byte(input int i, input logic [7:0] d, input logic last,
                           output int waits);
    logic rdy;
    bit   ok;
    s_tvalid[i] = 1'b1;
    s_tdata[i]  = d;
    s_tlast[i]  = last;
    waits = 0;
    ok    = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1 rdy = s_tready[i];
      @(negedge in_clock);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout dut%0d: s_tready stayed 0, required 1 within 100 cycles", i);
    end else begin
      exp_q.push_back({1'b0, d});
      mdl_acc = mdl_acc ^ d;
      mdl_len++;
      if (last || mdl_len == int'(MAXL_P[i])) begin
        exp_q.push_back({1'b1, mdl_acc ^ (ODD_P[i] ? 8'hFF : 8'h00)});
        mdl_acc = 8'h00;
        mdl_len = 0;
      end
    end
  endtask

  // Output collector: bit c of stall drops m_tready in collector cycle c.
  task automatic collect(input int i, input int n, input logic [31:0] stall);
    int got;
    got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge in_clock);
      m_tready[i] = (c < 32) ? !stall[c] : 1'b1;
      #2;
      if (m_tvalid[i] && m_tready[i]) begin
        obs_q.push_back({m_tlast[i], m_tdata[i]});
        got++;
      end
    end
    m_tready[i] = 1'b1;
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL collect_timeout dut%0d: got %0d beats, required %0d", i, got, n);
    end
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++; if (m_tvalid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid dut%0d: got %b required 0", i, m_tvalid[i]); end
      n_cmp++; if (m_tdata[i] !== 8'h00) begin n_bad++; $display("FAIL reset_m_tdata dut%0d: got %h required 00", i, m_tdata[i]); end
      n_cmp++; if (m_tlast[i] !== 1'b0) begin n_bad++; $display("FAIL reset_m_tlast dut%0d: got %b required 0", i, m_tlast[i]); end
      n_cmp++; if (pkt_count[i] !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_count dut%0d: got %0d required 0", i, pkt_count[i]); end
      n_cmp++; if (err_len[i] !== 1'b0) begin n_bad++; $display("FAIL reset_err_len dut%0d: got %b required 0", i, err_len[i]); end
      n_cmp++; if (s_tready[i] !== 1'b1) begin n_bad++; $display("FAIL reset_s_tready dut%0d: got %b required 1", i, s_tready[i]); end
      n_cmp++; if (dbg_state[i] !== 1'b0) begin n_bad++; $display("FAIL reset_state dut%0d: got %b required 0", i, dbg_state[i]); end
    end
  endtask

  task automatic test_basic();
    int w0, w1, w2, k;
    logic [8:0] o, e, last_o;
    apply_reset();
    fork
      begin send_byte(0, 8'h01, 1'b0, w0); send_byte(0, 8'h02, 1'b0, w1); send_byte(0, 8'h04, 1'b1, w2); end
      collect(0, 4, 32'h0);
    join
    k = 0;
    last_o = '0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      last_o = o;
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL basic_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (last_o !== 9'h107) begin n_bad++; $display("FAIL basic_lrc: got %h required 107", last_o); end
    @(negedge in_clock); #2;
    n_cmp++; if (m_tvalid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid: got %b required 0", m_tvalid[0]); end
    n_cmp++; if (pkt_count[0] !== 16'd1) begin n_bad++; $display("FAIL basic_pkt_count: got %0d required 1", pkt_count[0]); end
  endtask

  task automatic test_parity_odd();
    int w, k;
    logic [8:0] o, e;
    logic [8:0] lrc_odd;
    apply_reset();
    fork
      begin send_byte(1, 8'h01, 1'b0, w); send_byte(1, 8'h02, 1'b0, w); send_byte(1, 8'h04, 1'b1, w); end
      collect(1, 4, 32'h0);
    join
    lrc_odd = obs_q[obs_q.size()-1];
    n_cmp++; if (lrc_odd !== 9'h1F8) begin n_bad++; $display("FAIL odd_lrc: got %h required 1f8", lrc_odd); end
    fork
      send_byte(0, 8'hA5, 1'b1, w);
      collect(0, 2, 32'h0);
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL odd_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL odd_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL odd_missing: %0d beats outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int w, k;
    logic [8:0] o, e;
    apply_reset();
    fork
      begin send_byte(0, 8'h11, 1'b0, w); send_byte(0, 8'h22, 1'b0, w); send_byte(0, 8'h44, 1'b0, w); send_byte(0, 8'h88, 1'b1, w); end
      collect(0, 5, 32'h0000_001C);
      begin
        logic [8:0] held;
        held = '0;
        repeat (2) @(negedge in_clock);
        for (int s = 0; s < 3; s++) begin
          @(negedge in_clock); #3;
          n_cmp++; if (m_tvalid[0] !== 1'b1) begin n_bad++; $display("FAIL stall_valid cyc%0d: got %b required 1", s, m_tvalid[0]); end
          n_cmp++; if (s_tready[0] !== 1'b0) begin n_bad++; $display("FAIL stall_s_tready cyc%0d: got %b required 0", s, s_tready[0]); end
          if (s == 0) held = {m_tlast[0], m_tdata[0]};
          else begin
            n_cmp++;
            if ({m_tlast[0], m_tdata[0]} !== held) begin n_bad++; $display("FAIL stall_hold cyc%0d: got %h required %h", s, {m_tlast[0], m_tdata[0]}, held); end
          end
        end
      end
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL bp_beat%0d: got %h required %h", k, o, e); end end
      if (k == 4) begin n_cmp++; if (o !== 9'h1FF) begin n_bad++; $display("FAIL bp_lrc: got %h required 1ff", o); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_missing: %0d beats outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int w_ff, w_0f, w_33, k;
    logic [8:0] o, e;
    apply_reset();
    fork
      begin send_byte(0, 8'hFF, 1'b0, w_ff); send_byte(0, 8'h0F, 1'b1, w_0f); send_byte(0, 8'h33, 1'b1, w_33); end
      collect(0, 5, 32'h0);
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL b2b_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (w_0f !== 0) begin n_bad++; $display("FAIL b2b_mid_wait: got %0d cycles required 0", w_0f); end
    n_cmp++; if (w_33 !== 1) begin n_bad++; $display("FAIL b2b_bubble: got %0d cycles required 1", w_33); end
    @(negedge in_clock); #2;
    n_cmp++; if (m_tvalid[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_valid: got %b required 0", m_tvalid[0]); end
    n_cmp++; if (pkt_count[0] !== 16'd2) begin n_bad++; $display("FAIL b2b_pkt_count: got %0d required 2", pkt_count[0]); end
  endtask

  task automatic test_force_close();
    int w, w_01, k;
    logic [8:0] o, e;
    logic [7:0] bytes[6];
    bytes = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    w_01 = 0;
    apply_reset();
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          send_byte(2, bytes[b], (b == 5), w);
          if (b == 4) w_01 = w;
        end
      end
      collect(2, 8, 32'h0);
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL fc_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL fc_beat%0d: got %h required %h", k, o, e); end end
      if (k == 4) begin n_cmp++; if (o !== 9'h1F0) begin n_bad++; $display("FAIL fc_lrc: got %h required 1f0", o); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fc_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (w_01 !== 1) begin n_bad++; $display("FAIL fc_bubble: got %0d cycles required 1", w_01); end
    n_cmp++; if (err_len[2] !== 1'b1) begin n_bad++; $display("FAIL fc_err_len: got %b required 1", err_len[2]); end
    n_cmp++; if (pkt_count[2] !== 16'd2) begin n_bad++; $display("FAIL fc_pkt_count: got %0d required 2", pkt_count[2]); end
  endtask

  task automatic test_max_len_one();
    int w, k;
    logic [8:0] o, e;
    apply_reset();
    fork
      begin send_byte(3, 8'h3C, 1'b0, w); send_byte(3, 8'hC3, 1'b1, w); end
      collect(3, 4, 32'h0);
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL ml1_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL ml1_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ml1_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (err_len[3] !== 1'b1) begin n_bad++; $display("FAIL ml1_err_len: got %b required 1", err_len[3]); end
    n_cmp++; if (pkt_count[3] !== 16'd2) begin n_bad++; $display("FAIL ml1_pkt_count: got %0d required 2", pkt_count[3]); end
  endtask

  task automatic test_mid_reset();
    int w, k;
    logic [8:0] o, e;
    apply_reset();
    fork
      begin send_byte(0, 8'h0A, 1'b0, w); send_byte(0, 8'h0B, 1'b0, w); end
      collect(0, 1, 32'h0);
    join
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL mr_first: got %h required %h", o, e); end
    #1;
    n_cmp++; if ({m_tvalid[0], m_tdata[0]} !== 9'h10B) begin n_bad++; $display("FAIL mr_pending: got %h required 10b", {m_tvalid[0], m_tdata[0]}); end
    axis_aresetn = 1'b0;
    #1;
    n_cmp++; if ({m_tvalid[0], m_tlast[0], m_tdata[0]} !== 10'h000) begin n_bad++; $display("FAIL mr_async_clear: got %h required 000", {m_tvalid[0], m_tlast[0], m_tdata[0]}); end
    n_cmp++; if (dbg_state[0] !== 1'b0) begin n_bad++; $display("FAIL mr_state: got %b required 0", dbg_state[0]); end
    exp_q.delete();
    obs_q.delete();
    mdl_acc = 8'h00;
    mdl_len = 0;
    repeat (2) @(negedge in_clock);
    axis_aresetn = 1'b1;
    @(negedge in_clock);
    fork
      send_byte(0, 8'h05, 1'b1, w);
      collect(0, 2, 32'h0);
    join
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL mr_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL mr_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL mr_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (pkt_count[0] !== 16'd1) begin n_bad++; $display("FAIL mr_pkt_count: got %0d required 1", pkt_count[0]); end
  endtask

  // Random packets on dut0 with random backpressure.
  task automatic test_random();
    int w, k, len;
    logic [8:0] o, e;
    apply_reset();
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 6);
      fork
        for (int b = 0; b < len; b++) send_byte(0, 8'($urandom_range(0, 255)), (b == len - 1), w);
        collect(0, len + 1, 32'($urandom_range(0, 32'h7FFF_FFFF)) & 32'h0000_FFFF);
      join
    end
    k = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_beat%0d: got %h, required no beat", k, o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin n_bad++; $display("FAIL rnd_beat%0d: got %h required %h", k, o, e); end end
      k++;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_missing: %0d beats outstanding, required 0", exp_q.size()); end
    n_cmp++; if (pkt_count[0] !== 16'd6) begin n_bad++; $display("FAIL rnd_pkt_count: got %0d required 6", pkt_count[0]); end
  endtask

  initial begin
    axis_aresetn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      s_tvalid[i] = 1'b0;
      s_tdata[i]  = 8'h00;
      s_tlast[i]  = 1'b0;
      m_tready[i] = 1'b1;
    end
    test_reset();
    test_basic();
    test_parity_odd();
    test_backpressure();
    test_back_to_back();
    test_force_close();
    test_max_len_one();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
